mem_port_arbiter: RTL and testbench

//  - Shares one single-ported data memory between the ARM core's data port (MemWrite/ALU address/WriteData/ReadData)
//    and a secondary requester (program loader / debug DMA).
//  - Two-way round-robin arbitration with req/ack handshakes; sequences each access through a fixed-latency memory.
//  - Drives core_stall so the core freezes its PC while its access is pending.

---
 rtl/arb_pkg.sv | 15 +
 rtl/arb_rr_pick.sv | 24 ++
 rtl/mem_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } arb_state_t;

   // requester ids; also the bit positions in the picker's req vector
   localparam logic REQ_CORE = 1'b0;
   localparam logic REQ_LDR  = 1'b1;

endpackage

// File: rtl/arb_rr_pick.sv
// Two-way round-robin picker: a lone requester wins; on a tie the requester
// that was not served last wins.
module arb_rr_pick
   import arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic       gnt,
   output logic       any
);

   assign any = |req;

   // grant selection
   always_comb begin
      gnt = REQ_CORE;
      if (req == 2'b11) begin
         gnt = ~last;
      end else if (req[REQ_LDR]) begin
         gnt = REQ_LDR;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, fixed-latency data memory between the core data
// port and the loader/debug-DMA port. Optional saturating core stall-cycle
// counter is built when ARB_STALL_CNT_EN is defined.
//
// state | meaning
// IDLE  | no access in flight; arbitrate and latch the winner's attributes
// ISSUE | mem_en pulse with latched we/addr/wdata
// WAIT  | read latency countdown (only when MEM_LAT > 1)
// DONE  | winner's ack pulse; read data forwarded from mem_rdata
module mem_port_arbiter
   import arb_pkg::*;
#(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int MEM_LAT = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          core_req,
   input  logic          core_we,
   input  logic [AW-1:0] core_addr,
   input  logic [DW-1:0] core_wdata,
   output logic [DW-1:0] core_rdata,
   output logic          core_ack,
   output logic          core_stall,
   input  logic          ldr_req,
   input  logic          ldr_we,
   input  logic [AW-1:0] ldr_addr,
   input  logic [DW-1:0] ldr_wdata,
   output logic [DW-1:0] ldr_rdata,
   output logic          ldr_ack,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
`ifdef ARB_STALL_CNT_EN
   ,
   output logic [31:0]   stall_cnt
`endif
);

   localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) + 1 : 1;

   arb_state_t    state;
   logic          win;
   logic          win_we;
   logic          rr_last;
   logic [CW-1:0] lat_cnt;
   logic [DW-1:0] core_rdata_q;
   logic [DW-1:0] ldr_rdata_q;
   logic          pick_gnt;
   logic          pick_any;
   logic          win_req;

   arb_rr_pick u_pick (
      .req  ({ldr_req, core_req}),
      .last (rr_last),
      .gnt  (pick_gnt),
      .any  (pick_any)
   );

   assign win_req    = (win == REQ_LDR) ? ldr_req : core_req;
   assign core_stall = core_req & ~core_ack;

   // read data is forwarded in the ack cycle, otherwise the last read is held
   assign core_rdata = (core_ack && !win_we) ? mem_rdata : core_rdata_q;
   assign ldr_rdata  = (ldr_ack && !win_we) ? mem_rdata : ldr_rdata_q;

   // access sequencer: arbitrate, issue, wait out read latency, acknowledge
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         win          <= REQ_CORE;
         win_we       <= 1'b0;
         rr_last      <= REQ_LDR;
         lat_cnt      <= '0;
         mem_en       <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         core_ack     <= 1'b0;
         ldr_ack      <= 1'b0;
         core_rdata_q <= '0;
         ldr_rdata_q  <= '0;
      end else begin
         if (state != IDLE) begin
            assert (win_req)
               else $warning("mem_port_arbiter: requester %0d dropped req before ack", win);
         end
         case (state)
            IDLE: begin
               if (pick_any) begin
                  win       <= pick_gnt;
                  win_we    <= (pick_gnt == REQ_LDR) ? ldr_we : core_we;
                  mem_we    <= (pick_gnt == REQ_LDR) ? ldr_we : core_we;
                  mem_addr  <= (pick_gnt == REQ_LDR) ? ldr_addr : core_addr;
                  mem_wdata <= (pick_gnt == REQ_LDR) ? ldr_wdata : core_wdata;
                  mem_en    <= 1'b1;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               mem_en <= 1'b0;
               mem_we <= 1'b0;
               if (win_we || MEM_LAT == 1) begin
                  core_ack <= (win == REQ_CORE);
                  ldr_ack  <= (win == REQ_LDR);
                  state    <= DONE;
               end else begin
                  lat_cnt <= CW'(MEM_LAT - 1);
                  state   <= WAIT;
               end
            end
            WAIT: begin
               if (lat_cnt == CW'(1)) begin
                  core_ack <= (win == REQ_CORE);
                  ldr_ack  <= (win == REQ_LDR);
                  state    <= DONE;
               end else begin
                  lat_cnt <= lat_cnt - CW'(1);
               end
            end
            DONE: begin
               if (!win_we && win == REQ_CORE) core_rdata_q <= mem_rdata;
               if (!win_we && win == REQ_LDR)  ldr_rdata_q  <= mem_rdata;
               core_ack <= 1'b0;
               ldr_ack  <= 1'b0;
               rr_last  <= win;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ARB_STALL_CNT_EN
   // saturating count of cycles the core spends stalled
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt <= '0;
      end else if (core_stall && stall_cnt != 32'hFFFF_FFFF) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter (MEM_LAT=3) with a scoreboard of expected memory
// transactions and per-port completions. Checks stall_cnt when built with
// ARB_STALL_CNT_EN.
module tb_mem_port_arbiter;
   import arb_pkg::*;

   localparam int LAT = 3;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
   } acc_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        core_req, core_we, ldr_req, ldr_we;
   logic [31:0] core_addr, core_wdata, ldr_addr, ldr_wdata;
   logic [31:0] core_rdata, ldr_rdata, mem_addr, mem_wdata, mem_rdata;
   logic        core_ack, core_stall, ldr_ack, mem_en, mem_we;
`ifdef ARB_STALL_CNT_EN
   logic [31:0] stall_cnt;
`endif

   int n_chk, n_err, cyc;
   int mem_en_cnt, core_ack_cnt, ldr_ack_cnt, stall_cycles, last_mem_cyc;
   acc_t mem_q[$], core_q[$], ldr_q[$];

   logic [31:0] ram [64];
   bit   [63:0] ram_wr;
   logic [31:0] ref_mem [64];
   bit   [63:0] ref_wr;
   logic [31:0] rd_pipe [LAT];

   mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT)) dut (
      .clk        (clk),
      .reset      (reset),
      .core_req   (core_req),
      .core_we    (core_we),
      .core_addr  (core_addr),
      .core_wdata (core_wdata),
      .core_rdata (core_rdata),
      .core_ack   (core_ack),
      .core_stall (core_stall),
      .ldr_req    (ldr_req),
      .ldr_we     (ldr_we),
      .ldr_addr   (ldr_addr),
      .ldr_wdata  (ldr_wdata),
      .ldr_rdata  (ldr_rdata),
      .ldr_ack    (ldr_ack),
      .mem_en     (mem_en),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
`ifdef ARB_STALL_CNT_EN
      ,
      .stall_cnt  (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] init_val(input logic [5:0] idx);
      return (idx == 6'd32) ? 32'h1234_5678 : (32'h1000_0000 | 32'(idx));
   endfunction

   function automatic logic [31:0] ram_rd(input logic [5:0] idx);
      return ram_wr[idx] ? ram[idx] : init_val(idx);
   endfunction

   function automatic logic [31:0] ref_rd(input logic [5:0] idx);
      return ref_wr[idx] ? ref_mem[idx] : init_val(idx);
   endfunction

   // memory model: writes land at the edge, read data appears LAT cycles after mem_en
   always @(posedge clk) begin
      if (mem_en && mem_we) begin
         ram[mem_addr[7:2]]    <= mem_wdata;
         ram_wr[mem_addr[7:2]] <= 1'b1;
      end
      rd_pipe[0] <= (mem_en && !mem_we) ? ram_rd(mem_addr[7:2]) : 32'h0;
      for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign mem_rdata = rd_pipe[LAT-1];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_ctl"}, {mem_en, mem_we, core_ack, ldr_ack, core_stall}, 0);
      chk({tag, "_addr"}, mem_addr, 0);
      chk({tag, "_wdata"}, mem_wdata, 0);
      chk({tag, "_crd"}, core_rdata, 0);
      chk({tag, "_lrd"}, ldr_rdata, 0);
`ifdef ARB_STALL_CNT_EN
      chk({tag, "_scnt"}, stall_cnt, 0);
`endif
   endtask

   // push the predicted memory transaction and completion for one access
   task automatic expect_acc(input logic who, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata);
      acc_t e;
      e.we    = we;
      e.addr  = addr;
      e.wdata = wdata;
      e.rdata = ref_rd(addr[7:2]);
      if (we) begin
         ref_mem[addr[7:2]] = wdata;
         ref_wr[addr[7:2]]  = 1'b1;
      end
      mem_q.push_back(e);
      if (who == REQ_LDR) ldr_q.push_back(e);
      else core_q.push_back(e);
   endtask

   // hold a request until its ack, then release it; returns start and ack cycles
   task automatic drive_acc(input logic who, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, output int st, output int ac);
      st = cyc;
      ac = -1;
      if (who == REQ_LDR) begin
         ldr_we = we; ldr_addr = addr; ldr_wdata = wdata; ldr_req = 1'b1;
      end else begin
         core_we = we; core_addr = addr; core_wdata = wdata; core_req = 1'b1;
      end
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if ((who == REQ_LDR) ? ldr_ack : core_ack) begin
            ac = cyc;
            break;
         end
      end
      if (ac < 0) chk("ack_timeout", (who == REQ_LDR) ? ldr_ack : core_ack, 1'b1);
      @(posedge clk);
      #1;
      if (who == REQ_LDR) ldr_req = 1'b0;
      else core_req = 1'b0;
   endtask

   initial begin
      int   s0, a0, s1, a1, st_b, mc_b, ca_b, la_b;
      acc_t e;
`ifdef ARB_STALL_CNT_EN
      logic [31:0] sc_b;
`endif
      reset = 1'b0;
      core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0;
      ldr_req = 0; ldr_we = 0; ldr_addr = 0; ldr_wdata = 0;
      tick(3);

      // monitor: pops the scoreboard on every mem_en and ack
      fork
         forever begin
            @(negedge clk);
            if (mem_en) begin
               mem_en_cnt++;
               last_mem_cyc = cyc;
               if (mem_q.size() == 0) chk("mem_unexpected", mem_en, 1'b0);
               else begin
                  e = mem_q.pop_front();
                  chk("mem_we", mem_we, e.we);
                  chk("mem_addr", mem_addr, e.addr);
                  if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
               end
            end else begin
               chk("mem_we_idle", mem_we, 1'b0);
            end
            if (core_ack && ldr_ack) chk("dual_ack", ldr_ack, 1'b0);
            if (core_ack) begin
               core_ack_cnt++;
               if (core_q.size() == 0) chk("core_ack_unexpected", core_ack, 1'b0);
               else begin
                  e = core_q.pop_front();
                  if (!e.we) chk("core_rdata", core_rdata, e.rdata);
               end
            end
            if (ldr_ack) begin
               ldr_ack_cnt++;
               if (ldr_q.size() == 0) chk("ldr_ack_unexpected", ldr_ack, 1'b0);
               else begin
                  e = ldr_q.pop_front();
                  if (!e.we) chk("ldr_rdata", ldr_rdata, e.rdata);
               end
            end
            if (core_stall) stall_cycles++;
            chk("core_stall", core_stall, core_req & ~core_ack);
         end
      join_none

      @(negedge clk);
      chk_zero("rst_init");
      @(posedge clk);
      #1;
      reset = 1'b1;
      tick(2);

      // lone core write
      st_b = stall_cycles;
      expect_acc(REQ_CORE, 1'b1, 32'h40, 32'hDEAD_BEEF);
      drive_acc(REQ_CORE, 1'b1, 32'h40, 32'hDEAD_BEEF, s0, a0);
      chk("cwr_lat", a0 - s0, 2);
      chk("cwr_mem_cyc", last_mem_cyc - s0, 1);
      chk("cwr_stall", stall_cycles - st_b, 2);

      // core read back
      expect_acc(REQ_CORE, 1'b0, 32'h40, 32'h0);
      drive_acc(REQ_CORE, 1'b0, 32'h40, 32'h0, s0, a0);
      chk("crd_lat", a0 - s0, 1 + LAT);

      // lone loader read
      ca_b = core_ack_cnt;
      expect_acc(REQ_LDR, 1'b0, 32'h80, 32'h0);
      drive_acc(REQ_LDR, 1'b0, 32'h80, 32'h0, s0, a0);
      chk("lrd_lat", a0 - s0, 1 + LAT);
      chk("lrd_core_ack", core_ack_cnt - ca_b, 0);
      chk("lrd_ldr_rdata", ldr_rdata, 32'h1234_5678);
      chk("core_rdata_hold", core_rdata, 32'hDEAD_BEEF);

      // loader write, core reads it
      expect_acc(REQ_LDR, 1'b1, 32'h44, 32'hCAFE_F00D);
      drive_acc(REQ_LDR, 1'b1, 32'h44, 32'hCAFE_F00D, s0, a0);
      chk("lwr_lat", a0 - s0, 2);
      expect_acc(REQ_CORE, 1'b0, 32'h44, 32'h0);
      drive_acc(REQ_CORE, 1'b0, 32'h44, 32'h0, s0, a0);

      // reset in the middle of a loader read
      la_b = ldr_ack_cnt;
      expect_acc(REQ_LDR, 1'b0, 32'h84, 32'h0);
      ldr_we = 1'b0; ldr_addr = 32'h84; ldr_req = 1'b1;
      tick(2);
      reset   = 1'b0;
      ldr_req = 1'b0;
      #1;
      chk_zero("rst_mid");
      tick(2);
      reset = 1'b1;
      tick(5);
      chk("rst_no_ack", ldr_ack_cnt - la_b, 0);
      ldr_q.delete();
      chk("rst_mem_q", mem_q.size(), 0);

      // simultaneous reads after reset: core wins the first tie
      expect_acc(REQ_CORE, 1'b0, 32'h40, 32'h0);
      expect_acc(REQ_LDR, 1'b0, 32'h80, 32'h0);
      fork
         drive_acc(REQ_CORE, 1'b0, 32'h40, 32'h0, s0, a0);
         drive_acc(REQ_LDR, 1'b0, 32'h80, 32'h0, s1, a1);
      join
      chk("tie1_core_lat", a0 - s0, 1 + LAT);
      chk("tie1_ldr_lat", a1 - s1, 2 * (1 + LAT) + 1);

      // core served last, so the next tie goes to the loader
      expect_acc(REQ_CORE, 1'b1, 32'h48, 32'h0BAD_F00D);
      drive_acc(REQ_CORE, 1'b1, 32'h48, 32'h0BAD_F00D, s0, a0);
      expect_acc(REQ_LDR, 1'b0, 32'h48, 32'h0);
      expect_acc(REQ_CORE, 1'b0, 32'h80, 32'h0);
      fork
         drive_acc(REQ_CORE, 1'b0, 32'h80, 32'h0, s0, a0);
         drive_acc(REQ_LDR, 1'b0, 32'h48, 32'h0, s1, a1);
      join
      chk("tie2_ldr_lat", a1 - s1, 1 + LAT);
      chk("tie2_core_lat", a0 - s0, 2 * (1 + LAT) + 1);

      // core request arrives while the loader read is waiting
      st_b = stall_cycles;
`ifdef ARB_STALL_CNT_EN
      sc_b = stall_cnt;
`endif
      expect_acc(REQ_LDR, 1'b0, 32'h40, 32'h0);
      expect_acc(REQ_CORE, 1'b0, 32'h44, 32'h0);
      fork
         drive_acc(REQ_LDR, 1'b0, 32'h40, 32'h0, s1, a1);
         begin
            tick(2);
            drive_acc(REQ_CORE, 1'b0, 32'h44, 32'h0, s0, a0);
         end
      join
      chk("mid_ldr_lat", a1 - s1, 1 + LAT);
      chk("mid_core_lat", a0 - s0, 7);
      chk("mid_core_mem_cyc", last_mem_cyc - s1, 6);
      chk("mid_stall", stall_cycles - st_b, 7);
`ifdef ARB_STALL_CNT_EN
      chk("mid_stall_cnt", stall_cnt - sc_b, 7);
`endif

      // loader drops its request during WAIT
      mc_b = mem_en_cnt;
      la_b = ldr_ack_cnt;
      expect_acc(REQ_LDR, 1'b0, 32'h80, 32'h0);
      ldr_we = 1'b0; ldr_addr = 32'h80; ldr_req = 1'b1;
      tick(2);
      ldr_req = 1'b0;
      tick(8);
      chk("drop_mem_en", mem_en_cnt - mc_b, 1);
      chk("drop_ack", ldr_ack_cnt - la_b, 1);

      chk("sb_mem_empty", mem_q.size(), 0);
      chk("sb_core_empty", core_q.size(), 0);
      chk("sb_ldr_empty", ldr_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
